// File: rtl/dut_pkg.sv
// Shared constants, FSM state encoding and the distance helper for the
// pairwise min/max absolute-difference engine.
package dut_pkg;

    localparam int N_VALS    = 32;
    localparam int MEM_DEPTH = 256;
    localparam int MIN_ADDR  = 66;
    localparam int MAX_ADDR  = 68;

    typedef enum logic [3:0] {
        IDLE, LDA_HI, LDA_LO, LDB_HI, LDB_LO, CMP,
        WR0, WR1, WR2, WR3, DONE
    } state_t;

    // |a - b| for signed 16-bit operands; the 17-bit difference cannot overflow.
    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] diff;
        diff = {a[15], a} - {b[15], b};
        return diff[16] ? 16'(-diff) : diff[15:0];
    endfunction

endpackage

// File: rtl/dut_if.sv
// Start/done handshake between a requester (master) and the compute block (slave).
interface dut_if;
    logic start;
    logic done;

    modport master (output start, input done);
    modport slave  (input start, output done);
endinterface

// File: rtl/dut_data_mem.sv
// Byte-wide single-port data memory: combinational read, synchronous write.
module data_mem
    import dut_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] i_addr,
    input  logic       i_we,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata
);

    logic [7:0] core [MEM_DEPTH];

    // NOTE: the storage array is deliberately not reset; contents must survive a block reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            core[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = core[i_addr];

endmodule

// File: rtl/dut.sv
// Walks every operand pair (j < k), tracks min/max |A - B| and writes both
// results back into the data memory, under a start/done handshake.
module dut
    import dut_pkg::*;
(
    input  logic clk,
    input  logic reset,
    dut_if.slave bus
);

    localparam logic [5:0] LAST_K = 6'(N_VALS - 1);
    localparam logic [5:0] LAST_J = 6'(N_VALS - 2);

    state_t      r_state;
    state_t      w_next;
    logic        r_done;
    logic        r_armed;
    logic [5:0]  r_j;
    logic [5:0]  r_k;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_min;
    logic [15:0] r_max;

    logic [7:0]  w_addr;
    logic        w_we;
    logic [7:0]  w_wdata;
    logic [7:0]  w_rdata;
    logic [15:0] w_dist;

    data_mem dm (
        .clk     (clk),
        .i_addr  (w_addr),
        .i_we    (w_we),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign w_dist   = abs_diff(r_a, r_b);
    assign bus.done = r_done;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A run only launches after start has been seen high, so reset alone never starts one.
    always_comb begin
        // NOTE: default first, so no path through this block can infer a latch.
        w_next = r_state;
        if (bus.start && r_state != IDLE) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (!bus.start && r_armed) w_next = LDA_HI;
                LDA_HI:  w_next = LDA_LO;
                LDA_LO:  w_next = LDB_HI;
                LDB_HI:  w_next = LDB_LO;
                LDB_LO:  w_next = CMP;
                CMP: begin
                    if (r_k == LAST_K) begin
                        w_next = (r_j == LAST_J) ? WR0 : LDA_HI;
                    end else begin
                        w_next = LDB_HI;
                    end
                end
                WR0:     w_next = WR1;
                WR1:     w_next = WR2;
                WR2:     w_next = WR3;
                WR3:     w_next = DONE;
                DONE:    w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_addr  = 8'd0;
        w_we    = 1'b0;
        w_wdata = 8'd0;
        unique case (r_state)
            LDA_HI: w_addr = {1'b0, r_j[5:0] & 6'h1F, 1'b0};
            LDA_LO: w_addr = {1'b0, r_j[5:0] & 6'h1F, 1'b1};
            LDB_HI: w_addr = {1'b0, r_k[5:0] & 6'h1F, 1'b0};
            LDB_LO: w_addr = {1'b0, r_k[5:0] & 6'h1F, 1'b1};
            WR0: begin w_addr = 8'(MIN_ADDR);     w_we = 1'b1; w_wdata = r_min[15:8]; end
            WR1: begin w_addr = 8'(MIN_ADDR + 1); w_we = 1'b1; w_wdata = r_min[7:0];  end
            WR2: begin w_addr = 8'(MAX_ADDR);     w_we = 1'b1; w_wdata = r_max[15:8]; end
            WR3: begin w_addr = 8'(MAX_ADDR + 1); w_we = 1'b1; w_wdata = r_max[7:0];  end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_done <= (w_next == DONE);
            if (bus.start) begin
                r_armed <= 1'b1;
            end else if (r_state == IDLE) begin
                r_armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_min <= 16'hFFFF;
            r_max <= 16'h0000;
            r_j   <= 6'd0;
            r_k   <= 6'd1;
            r_a   <= 16'h0000;
            r_b   <= 16'h0000;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_min <= 16'hFFFF;
                    r_max <= 16'h0000;
                    r_j   <= 6'd0;
                    r_k   <= 6'd1;
                end
                LDA_HI: r_a[15:8] <= w_rdata;
                LDA_LO: r_a[7:0]  <= w_rdata;
                LDB_HI: r_b[15:8] <= w_rdata;
                LDB_LO: r_b[7:0]  <= w_rdata;
                CMP: begin
                    if (w_dist < r_min) r_min <= w_dist;
                    if (w_dist > r_max) r_max <= w_dist;
                    if (r_k == LAST_K) begin
                        r_j <= r_j + 6'd1;
                        r_k <= r_j + 6'd2;
                    end else begin
                        r_k <= r_k + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dut.sv
// Scoreboard bench: each launched run pushes its expected min/max; a monitor
// pops and compares result bytes and untouched memory whenever done rises.
module tb_dut;
    import dut_pkg::*;

    logic clk = 1'b0;
    logic reset;
    dut_if bus ();

    dut u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] mn;
        logic [15:0] mx;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  shadow [MEM_DEPTH];
    logic [15:0] ops [N_VALS];
    logic        done_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        u_dut.dm.core[a] = v;
        shadow[a] = v;
    endtask

    task automatic load_ops();
        for (int i = 0; i < N_VALS; i++) begin
            poke(2 * i, ops[i][15:8]);
            poke(2 * i + 1, ops[i][7:0]);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N_VALS; i++) ops[i] = 16'($urandom);
    endtask

    // Independent reference: brute-force over all pairs with plain integers.
    task automatic model(output logic [15:0] mn, output logic [15:0] mx);
        int lo = 65536;
        int hi = -1;
        for (int i = 0; i < N_VALS; i++) begin
            for (int j = i + 1; j < N_VALS; j++) begin
                int d = int'($signed(ops[i])) - int'($signed(ops[j]));
                if (d < 0) d = -d;
                if (d < lo) lo = d;
                if (d > hi) hi = d;
            end
        end
        mn = 16'(lo);
        mx = 16'(hi);
    endtask

    task automatic push(input string name, input logic [15:0] mn, input logic [15:0] mx);
        exp_t e;
        e.name = name;
        e.mn   = mn;
        e.mx   = mx;
        sb.push_back(e);
    endtask

    task automatic push_model(input string name);
        logic [15:0] mn, mx;
        model(mn, mx);
        push(name, mn, mx);
    endtask

    // Hold start high for n cycles; optionally check done drops after one edge.
    task automatic idle(input int n, input bit chk_drop);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (chk_drop) check("done_drop", 32'(bus.done), 32'd0);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic run(input string name);
        int lat = 0;
        bus.start = 1'b0;
        @(posedge clk);
        while (lat < 2000) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.done) break;
        end
        check({name, "_latency"}, 32'(lat), 32'd1554);
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input int n, output int highs);
        highs = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.done) highs++;
        end
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.done && !done_q) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                int   bad = 0;
                e = sb.pop_front();
                check({e.name, "_min"}, {16'd0, u_dut.dm.core[MIN_ADDR], u_dut.dm.core[MIN_ADDR+1]}, {16'd0, e.mn});
                check({e.name, "_max"}, {16'd0, u_dut.dm.core[MAX_ADDR], u_dut.dm.core[MAX_ADDR+1]}, {16'd0, e.mx});
                for (int i = 0; i < MEM_DEPTH; i++) begin
                    if ((i < 64 || i > 69) && u_dut.dm.core[i] !== shadow[i]) bad++;
                end
                check({e.name, "_untouched"}, 32'(bad), 32'd0);
            end
        end
        done_q = bus.done;
    end

    initial begin
        int highs;
        reset     = 1'b1;
        bus.start = 1'b1;
        for (int i = 0; i < MEM_DEPTH; i++) poke(i, 8'($urandom));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_done", 32'(bus.done), 32'd0);

        for (int i = 0; i < N_VALS; i++) ops[i] = 16'(i);
        load_ops();
        push("ascending", 16'h0001, 16'h001F);
        idle(2, 1'b0);
        run("ascending");

        for (int i = 0; i < N_VALS; i++) ops[i] = 16'h0000;
        ops[5]  = 16'h8000;
        ops[20] = 16'h7FFF;
        load_ops();
        push("extremes", 16'h0000, 16'hFFFF);
        idle(2, 1'b1);
        run("extremes");

        for (int i = 0; i < N_VALS; i++) ops[i] = 16'(i * 100 - 1500);
        ops[7] = ops[12];
        load_ops();
        push("ramp_dup", 16'h0000, 16'd3100);
        idle(2, 1'b1);
        run("ramp_dup");

        poke(66, 8'hFF);
        poke(67, 8'hFF);
        for (int i = 70; i < MEM_DEPTH; i++) poke(i, 8'h00);
        rand_ops();
        load_ops();
        push_model("preset_rand");
        idle(2, 1'b1);
        run("preset_rand");

        rand_ops();
        load_ops();
        idle(2, 1'b1);
        bus.start = 1'b0;
        hold(500, highs);
        check("abort_pre_highs", 32'(highs), 32'd0);
        bus.start = 1'b1;
        hold(20, highs);
        check("abort_post_highs", 32'(highs), 32'd0);
        push_model("after_abort");
        run("after_abort");

        for (int r = 0; r < 10; r++) begin
            rand_ops();
            load_ops();
            push_model($sformatf("b2b%0d", r));
            idle(2, 1'b1);
            run($sformatf("b2b%0d", r));
        end

        // done is high here; reset must clear it without a clock edge.
        reset = 1'b1;
        #1;
        check("reset_async_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 66; i < 70; i++) poke(i, 8'h5A);
        hold(1700, highs);
        check("post_reset_idle_highs", 32'(highs), 32'd0);
        check("post_reset_results", {u_dut.dm.core[66], u_dut.dm.core[67], u_dut.dm.core[68], u_dut.dm.core[69]}, 32'h5A5A5A5A);

        rand_ops();
        load_ops();
        idle(2, 1'b0);
        bus.start = 1'b0;
        hold(300, highs);
        reset = 1'b1;
        #1;
        check("midrun_reset_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        hold(100, highs);
        check("midrun_reset_idle_highs", 32'(highs), 32'd0);
        push_model("after_reset");
        idle(2, 1'b0);
        run("after_reset");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
